// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the line-granular data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    function automatic int idx_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_line_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_line_array
// Description : Single-port DEPTH x LINE_W line store, sync write, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_line_array #(
    parameter int DEPTH  = 512,
    parameter int LINE_W = 256,
    parameter int IDX_W  = dmem_pkg::idx_width(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);
    import dmem_pkg::*;

    logic [LINE_W-1:0] r_mem [DEPTH];
    logic [LINE_W-1:0] r_rdata;

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            r_mem[addr_i] <= wdata_i;
        end
    end

    // Read register only updates on a read, so it holds until the next one.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rdata <= '0;
        end else if (en_i && !we_i) begin
            r_rdata <= r_mem[addr_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_line_ctrl
// Description : Fixed-latency line read/write controller with saturating stats.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_line_ctrl #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512,
    parameter int LINE_W  = 256,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic [LINE_W-1:0] data_o,
    output logic              ack_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  rd_cnt_o,
    output logic [CNT_W-1:0]  wr_cnt_o
);
    import dmem_pkg::*;

    localparam int         c_idx_w    = idx_width(DEPTH);
    localparam logic [7:0] c_lat_load = 8'(LATENCY - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_tmr;
    logic                r_write;
    logic [c_idx_w-1:0]  r_line;
    logic [LINE_W-1:0]   r_wdata;
    logic                r_ack;
    logic [CNT_W-1:0]    r_rd_cnt;
    logic [CNT_W-1:0]    r_wr_cnt;
    logic                w_accept;
    logic                w_done;
    logic                w_unused_addr;

    assign w_accept = (r_state == ST_IDLE) && enable_i;
    assign w_done   = (r_state == ST_WAIT) && (r_tmr == 8'd0);

    // Offset and bits above the line index are don't-care; upper bits alias.
    assign w_unused_addr = ^{addr_i[31:OFFSET_W+c_idx_w], addr_i[OFFSET_W-1:0]};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (enable_i) w_state_next = ST_WAIT;
            ST_WAIT: if (r_tmr == 8'd0) w_state_next = ST_ACK;
            ST_ACK:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= ST_IDLE;
            r_tmr    <= 8'd0;
            r_ack    <= 1'b0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_done;
            if (w_accept) begin
                r_tmr <= c_lat_load;
            end else if ((r_state == ST_WAIT) && (r_tmr != 8'd0)) begin
                r_tmr <= r_tmr - 8'd1;
            end
            if (r_state == ST_ACK) begin
                if (r_write && (r_wr_cnt != '1)) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                if (!r_write && (r_rd_cnt != '1)) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
        end
    end

    // Request capture needs no reset: it is only consumed after an accept.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_write <= write_i;
            r_line  <= addr_i[OFFSET_W +: c_idx_w];
            r_wdata <= data_i;
        end
    end

    dmem_line_array #(
        .DEPTH  (DEPTH),
        .LINE_W (LINE_W),
        .IDX_W  (c_idx_w)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (w_done),
        .we_i    (r_write),
        .addr_i  (r_line),
        .wdata_i (r_wdata),
        .rdata_o (data_o)
    );

    assign ack_o    = r_ack;
    assign busy_o   = (r_state == ST_WAIT) || (r_state == ST_ACK);
    assign rd_cnt_o = r_rd_cnt;
    assign wr_cnt_o = r_wr_cnt;

endmodule
`default_nettype wire

// File: doc/dmem_line_ctrl.md
Name: dmem_line_ctrl

Overview:
- Backing data memory directly downstream of the data cache; serves whole 256-bit cache lines over an enable/write/ack handshake with fixed programmable latency.
- Accepts one line read (refill) or line write (write-back) at a time; holds the request internally and returns a one-cycle ack when done.
- Also keeps saturating read/write transaction counters for performance runs.

Parameters:
- LATENCY, 10, cycles from request acceptance to the ack edge; legal range 1..255.
- DEPTH, 512, number of 256-bit lines; a power of two; 512 lines = 16 KiB.
- LINE_W, 256, line width in bits.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- enable_i  in  1  request valid; sampled only in IDLE.
- write_i  in  1  1 = line write, 0 = line read; sampled with enable_i.
- addr_i  in  32  byte address; [4:0] ignored; [5+log2(DEPTH)-1:5] selects the line; upper bits ignored (aliasing).
- data_i  in  LINE_W  write line; sampled with enable_i.
- data_o  out  LINE_W  read line; valid while ack_o=1 and held until the next read completes.
- ack_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high in WAIT and ACK.
- rd_cnt_o  out  CNT_W  completed reads; saturating.
- wr_cnt_o  out  CNT_W  completed writes; saturating.

Behaviour:
- Reset values: ack_o=0, busy_o=0, data_o=0, rd_cnt_o=0, wr_cnt_o=0, state=IDLE, counter=0.
- Reset does not clear the storage array. Reset mid-operation aborts the transaction; a pending write is dropped and no ack is produced.
- States are IDLE, WAIT and ACK.
- IDLE:
  - On an edge with enable_i=1, latch addr_i, write_i and data_i into request registers.
  - Load the counter with LATENCY-1 and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If counter != 0, decrement it.
  - If counter == 0:
    - For a write, commit the latched data to the array.
    - For a read, register array[line] into data_o.
    - Go to ACK.
- ACK:
  - ack_o=1 for exactly this cycle.
  - Increment rd_cnt_o or wr_cnt_o, saturating at all-ones.
  - Go to IDLE unconditionally.
- Latency: request accepted at edge T; ack_o is high in the cycle after edge T+LATENCY. Back-to-back requests start at T+LATENCY+2 at the earliest.
- enable_i, write_i, addr_i and data_i are ignored in WAIT and ACK. A request is committed once accepted, even if enable_i drops.
- A requester holding enable_i high across its own ack issues a second transaction using the values present in the next IDLE cycle. Example: write-back immediately followed by refill.
- A read issued after a write to the same line returns the new data; the write commits before ack.
- data_o is not altered by write transactions.
- ack_o and data_o are registered outputs; no combinational path from any input.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum (IDLE/WAIT/ACK);
  - LINE_W, OFFSET_W=5;
  - a function returning the index width from DEPTH.
- Sub-module dmem_line_array holds the storage: synchronous write, synchronous registered read, single port, DEPTH x LINE_W.
- The controller FSM, latency counter and stats counters live in dmem_line_ctrl.

Test Plan:
- Write 0xA5 repeated across the line to addr 0x0000_0040, then read it back (LATENCY=10). Required:
  - ack_o pulses exactly 11 cycles after each accept edge;
  - read data_o = 0xA5…A5;
  - wr_cnt_o=1, rd_cnt_o=1.
- Drop enable_i one cycle after accepting a write of 0x1234… to line 3. Required: ack still pulses at T+LATENCY+1 and a later read of line 3 returns 0x1234….
- Hold enable_i high across a write ack with addr switched to 0x0000_0400 and write_i=0. Required: a second transaction is accepted in the IDLE cycle after the ack, and a second ack pulse follows 11 cycles later.
- Assert reset in WAIT midway through a write to line 7 holding old value X. Required: no ack, busy_o=0 immediately, and a subsequent read of line 7 returns X.
- Aliasing check with DEPTH=512: write to 0x0000_4020, read 0x0000_0020. Required: the read returns the same line; addr bits [4:0]=0x1F make no difference.
- With CNT_W=4, issue 17 reads. Required: rd_cnt_o saturates at 15.
